// File: rtl/jt900h_sim_pkg.sv
// Shared definitions for the simulation bus model: controller state encoding
// and the default stop-signal address.
package jt900h_sim_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [23:0] STOPA_DEFAULT = 24'h00ffff;

endpackage

// File: rtl/jt900h_simbus_if.sv
// CPU-side bus bundle: byte address, write data/enables, read data, plus the
// ready and clock-enable qualifiers that gate RAM writes.
interface jt900h_simbus_if;

    logic [23:0] addr;
    logic [15:0] dout;
    logic [1:0]  we;
    logic [15:0] din;
    logic        rdy;
    logic        cen;

    // master: the side that owns address, data and the write qualifiers
    modport master (output addr, dout, we, rdy, cen, input din);
    modport slave  (input addr, dout, we, rdy, cen, output din);

endinterface

// File: rtl/jt900h_simram.sv
// 16-bit simulation RAM with byte-lane writes and asynchronous read.
// Writes only land when the bus is ready and the CPU clock is enabled.
module jt900h_simram #(
    parameter int AW = 12
) (
    input logic            clk,
    jt900h_simbus_if.slave bus
);

    localparam int DEPTH = 2 ** (AW - 1);

    logic [15:0]   mem [0:DEPTH-1];
    logic [AW-2:0] wa;
    logic          unused_addr;

    assign wa          = bus.addr[AW-1:1];
    assign unused_addr = ^{bus.addr[23:AW], bus.addr[0]};
    assign bus.din     = mem[wa];

    // NOTE: the array has no reset so it stays a plain RAM; contents come from preload or writes.
    always_ff @(posedge clk) begin
        if (bus.cen && bus.rdy) begin
            if (bus.we[0]) mem[wa][7:0]  <= bus.dout[7:0];
            if (bus.we[1]) mem[wa][15:8] <= bus.dout[15:8];
        end
    end

endmodule

// File: rtl/jt900h_simbus.sv
// Simulation bus for the TLCS-900H core: RAM with wait states, CPU clock
// enable, and a stop/timeout-triggered register dump into a readable buffer.
module jt900h_simbus
    import jt900h_sim_pkg::*;
#(
    parameter int          AW     = 12,
    parameter int          WAIT   = 0,
    parameter int          CENDIV = 1,
    parameter int          DMPLEN = 84,
    parameter logic [23:0] STOPA  = STOPA_DEFAULT,
    parameter int          TMO    = 100000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cen,
    input  logic [23:0] addr,
    output logic [15:0] din,
    input  logic [15:0] dout,
    input  logic [1:0]  we,
    output logic        rdy,
    output logic [7:0]  dmp_addr,
    input  logic [7:0]  dmp_din,
    input  logic [7:0]  buf_a,
    output logic [7:0]  buf_q,
    output logic [1:0]  st,
    output logic        tmo_flag
);

    localparam logic [3:0]  WAIT_N   = 4'(WAIT);
    localparam logic [8:0]  DMP_LAST = 9'(DMPLEN);
    localparam logic [31:0] TMO_LAST = (TMO > 0) ? 32'(TMO - 1) : 32'd0;

    state_t        state;
    logic          cen_r;
    logic [8:0]    dcnt;
    logic [31:0]   tcnt;
    logic [3:0]    wcnt;
    logic [AW-2:0] prev_wa;
    logic [1:0]    prev_we;
    logic          addr_chg;
    logic          stop_wr;
    logic          tmo_hit;
    logic          cap_en;
    logic [7:0]    buf_mem [0:255];

    jt900h_simbus_if ram_bus ();

    assign ram_bus.addr = addr;
    assign ram_bus.dout = dout;
    assign ram_bus.we   = we;
    assign ram_bus.rdy  = rdy;
    assign ram_bus.cen  = cen_r;
    assign din          = ram_bus.din;

    jt900h_simram #(.AW(AW)) u_ram (
        .clk (clk),
        .bus (ram_bus.slave)
    );

    // rdy must fall in the very cycle the access changes, so it is not registered
    assign addr_chg = (addr[AW-1:1] != prev_wa) || (we != prev_we);
    assign rdy      = (WAIT == 0) ? 1'b1 : (!addr_chg && wcnt == WAIT_N);

    assign stop_wr  = (state == ST_RUN) && cen_r && rdy && we[1] && (addr == STOPA);
    assign tmo_hit  = (TMO > 0) && (tcnt == TMO_LAST);
    assign cap_en   = (state == ST_DUMP) && (dcnt != 9'd0);

    assign cen      = cen_r;
    assign st       = state;
    assign dmp_addr = dcnt[7:0];
    assign buf_q    = ({1'b0, buf_a} < DMP_LAST) ? buf_mem[buf_a] : 8'h00;

    // Counts up from the last access change; ready once it reaches WAIT.
    always_ff @(posedge clk) begin
        prev_wa <= addr[AW-1:1];
        prev_we <= we;
        if (!rst) begin
            wcnt <= 4'd0;
        end else if (addr_chg) begin
            wcnt <= 4'd1;
        end else if (wcnt != WAIT_N) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            cen_r    <= 1'b1;
            dcnt     <= 9'd0;
            tcnt     <= 32'd0;
            tmo_flag <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    tcnt <= tcnt + 32'd1;
                    if (stop_wr) begin
                        state <= ST_DUMP;
                        cen_r <= 1'b0;
                    end else if (tmo_hit) begin
                        state    <= ST_DUMP;
                        cen_r    <= 1'b0;
                        tmo_flag <= 1'b1;
                    end else begin
                        cen_r <= (CENDIV == 2) ? !cen_r : 1'b1;
                    end
                end
                ST_DUMP: begin
                    // dcnt holds at DMPLEN so dmp_addr reads DMPLEN (mod 256) in DONE
                    if (dcnt == DMP_LAST) state <= ST_DONE;
                    else                  dcnt  <= dcnt + 9'd1;
                end
                default: begin
                    cen_r <= 1'b0;
                end
            endcase
        end
    end

    // dmp_din lags dmp_addr by a cycle, so it belongs one slot back
    always_ff @(posedge clk) begin
        if (cap_en) buf_mem[dcnt[7:0] - 8'd1] <= dmp_din;
    end

endmodule

// File: tb/tb_jt900h_simbus.sv
// Self-checking bench for jt900h_simbus: two instances cover the zero-wait
// stop/dump path and the wait-state, clock-divider and timeout path.
module tb_jt900h_simbus;
    import jt900h_sim_pkg::*;

    localparam int          DMP_A  = 32;
    localparam logic [23:0] STOP_A = 24'h000ffe;
    localparam int          WAIT_B = 3;
    localparam int          DMP_B  = 8;
    localparam int          TMO_B  = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jt900h_simbus_if bus_a ();
    jt900h_simbus_if bus_b ();

    logic [7:0] dmp_addr_a, dmp_din_a, buf_a_a, buf_q_a;
    logic [7:0] dmp_addr_b, dmp_din_b, buf_a_b, buf_q_b;
    logic [1:0] st_a, st_b;
    logic       tmo_a, tmo_b;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] rf_a [0:DMP_A-1];
    logic [7:0] rf_b [0:DMP_B-1];

    jt900h_simbus #(.AW(12), .WAIT(0), .CENDIV(1), .DMPLEN(DMP_A), .STOPA(STOP_A), .TMO(0)) u_a (
        .clk(clk), .rst(rst), .cen(bus_a.cen), .addr(bus_a.addr), .din(bus_a.din),
        .dout(bus_a.dout), .we(bus_a.we), .rdy(bus_a.rdy), .dmp_addr(dmp_addr_a),
        .dmp_din(dmp_din_a), .buf_a(buf_a_a), .buf_q(buf_q_a), .st(st_a), .tmo_flag(tmo_a)
    );

    jt900h_simbus #(.AW(12), .WAIT(WAIT_B), .CENDIV(2), .DMPLEN(DMP_B), .TMO(TMO_B)) u_b (
        .clk(clk), .rst(rst), .cen(bus_b.cen), .addr(bus_b.addr), .din(bus_b.din),
        .dout(bus_b.dout), .we(bus_b.we), .rdy(bus_b.rdy), .dmp_addr(dmp_addr_b),
        .dmp_din(dmp_din_b), .buf_a(buf_a_b), .buf_q(buf_q_b), .st(st_b), .tmo_flag(tmo_b)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus_a.addr = 24'h0; bus_a.dout = 16'h0; bus_a.we = 2'b00;
        bus_b.addr = 24'h0; bus_b.dout = 16'h0; bus_b.we = 2'b00;
        dmp_din_a = 8'h00; dmp_din_b = 8'h00; buf_a_a = 8'h00; buf_a_b = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (st_a !== ST_RUN) $display("FAIL reset_st_a: got %0d expected 0", st_a); else n_pass++;
        n_chk++; if (bus_a.cen !== 1'b1) $display("FAIL reset_cen_a: got %b expected 1", bus_a.cen); else n_pass++;
        n_chk++; if (bus_a.rdy !== 1'b1) $display("FAIL reset_rdy_a: got %b expected 1", bus_a.rdy); else n_pass++;
        n_chk++; if (dmp_addr_a !== 8'd0) $display("FAIL reset_dmp_addr_a: got %0d expected 0", dmp_addr_a); else n_pass++;
        n_chk++; if (tmo_a !== 1'b0) $display("FAIL reset_tmo_a: got %b expected 0", tmo_a); else n_pass++;
        n_chk++; if (st_b !== ST_RUN) $display("FAIL reset_st_b: got %0d expected 0", st_b); else n_pass++;
        n_chk++; if (bus_b.cen !== 1'b1) $display("FAIL reset_cen_b: got %b expected 1", bus_b.cen); else n_pass++;
        n_chk++; if (bus_b.rdy !== 1'b0) $display("FAIL reset_rdy_b: got %b expected 0", bus_b.rdy); else n_pass++;
        n_chk++; if (tmo_b !== 1'b0) $display("FAIL reset_tmo_b: got %b expected 0", tmo_b); else n_pass++;
    endtask

    task automatic test_write();
        logic [15:0] ref_w [0:7];
        logic [10:0] wa_l  [0:7];
        bus_a.addr = 24'h000010; bus_a.dout = 16'h1234; bus_a.we = 2'b11;
        @(negedge clk);
        bus_a.dout = 16'hA55A; bus_a.we = 2'b01;
        @(negedge clk);
        bus_a.we = 2'b00;
        #1;
        n_chk++; if (bus_a.din !== 16'h125A) $display("FAIL lane_write: got %h expected 125a", bus_a.din); else n_pass++;
        // fill eight distinct words, then scatter random byte-lane writes over them
        for (int i = 0; i < 8; i++) begin
            wa_l[i]    = 11'(i * 37 + int'($urandom_range(0, 30)));
            ref_w[i]   = 16'($urandom);
            bus_a.addr = {12'h000, wa_l[i], 1'b0};
            bus_a.dout = ref_w[i];
            bus_a.we   = 2'b11;
            @(negedge clk);
        end
        for (int n = 0; n < 24; n++) begin
            int          k;
            logic [15:0] d;
            logic [1:0]  w;
            k = int'($urandom_range(0, 7));
            d = 16'($urandom);
            w = 2'($urandom_range(1, 3));
            bus_a.addr = {12'h000, wa_l[k], 1'($urandom)};
            bus_a.dout = d;
            bus_a.we   = w;
            if (w[0]) ref_w[k][7:0]  = d[7:0];
            if (w[1]) ref_w[k][15:8] = d[15:8];
            @(negedge clk);
        end
        bus_a.we = 2'b00;
        for (int i = 0; i < 8; i++) begin
            bus_a.addr = {12'($urandom), wa_l[i], 1'($urandom)};
            #1;
            n_chk++; if (bus_a.din !== ref_w[i]) $display("FAIL readback[%0d]: got %h expected %h", i, bus_a.din, ref_w[i]); else n_pass++;
        end
        n_chk++; if (bus_a.cen !== 1'b1) $display("FAIL run_cen_a: got %b expected 1", bus_a.cen); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stop();
        logic [15:0] d;
        int          i;
        bus_a.addr = 24'h0007e0; bus_a.dout = 16'h5AA5; bus_a.we = 2'b11;
        @(negedge clk);
        for (int k = 0; k < DMP_A; k++) rf_a[k] = 8'($urandom);
        d = 16'($urandom);
        bus_a.addr = STOP_A; bus_a.dout = d; bus_a.we = 2'b10;
        @(negedge clk);
        bus_a.we = 2'b00;
        #1;
        n_chk++; if (st_a !== ST_DUMP) $display("FAIL stop_st: got %0d expected 1", st_a); else n_pass++;
        n_chk++; if (bus_a.cen !== 1'b0) $display("FAIL stop_cen: got %b expected 0", bus_a.cen); else n_pass++;
        n_chk++; if (bus_a.din[15:8] !== d[15:8]) $display("FAIL stop_write: got %h expected %h", bus_a.din[15:8], d[15:8]); else n_pass++;
        // CPU access attempted while dumping must be ignored
        bus_a.addr = 24'h0007e0; bus_a.dout = 16'hFFFF; bus_a.we = 2'b11;
        i = 0;
        while (st_a == ST_DUMP && i <= DMP_A + 4) begin
            n_chk++; if (dmp_addr_a !== 8'(i)) $display("FAIL dump_addr[%0d]: got %0d expected %0d", i, dmp_addr_a, i); else n_pass++;
            dmp_din_a = (i > 0 && i <= DMP_A) ? rf_a[i-1] : 8'($urandom);
            @(negedge clk);
            i++;
        end
        n_chk++; if (i !== DMP_A + 1) $display("FAIL dump_len: got %0d expected %0d", i, DMP_A + 1); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (st_a !== ST_DONE) $display("FAIL done_st: got %0d expected 2", st_a); else n_pass++;
        n_chk++; if (dmp_addr_a !== 8'(DMP_A)) $display("FAIL done_dmp_addr: got %0d expected %0d", dmp_addr_a, DMP_A); else n_pass++;
        n_chk++; if (tmo_a !== 1'b0) $display("FAIL stop_tmo: got %b expected 0", tmo_a); else n_pass++;
        n_chk++; if (bus_a.cen !== 1'b0) $display("FAIL done_cen: got %b expected 0", bus_a.cen); else n_pass++;
        bus_a.we = 2'b00;
        #1;
        n_chk++; if (bus_a.din !== 16'h5AA5) $display("FAIL ignored_write: got %h expected 5aa5", bus_a.din); else n_pass++;
        for (int a = 0; a < DMP_A + 4; a++) begin
            logic [7:0] exp_q;
            exp_q   = (a < DMP_A) ? rf_a[a] : 8'h00;
            buf_a_a = 8'(a);
            #1;
            n_chk++; if (buf_q_a !== exp_q) $display("FAIL buf_a[%0d]: got %h expected %h", a, buf_q_a, exp_q); else n_pass++;
        end
        buf_a_a = 8'hFF;
        #1;
        n_chk++; if (buf_q_a !== 8'h00) $display("FAIL buf_a_oob: got %h expected 00", buf_q_a); else n_pass++;
    endtask

    task automatic test_reset_in_dump();
        int n;
        do_reset();
        bus_a.addr = STOP_A; bus_a.dout = 16'($urandom); bus_a.we = 2'b10;
        @(negedge clk);
        bus_a.we = 2'b00;
        n = 0;
        while (dmp_addr_a != 8'd20 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_chk++; if (dmp_addr_a !== 8'd20) $display("FAIL reach_dmp20: got %0d expected 20", dmp_addr_a); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (st_a !== ST_RUN) $display("FAIL abort_st: got %0d expected 0", st_a); else n_pass++;
        n_chk++; if (dmp_addr_a !== 8'd0) $display("FAIL abort_dmp_addr: got %0d expected 0", dmp_addr_a); else n_pass++;
        n_chk++; if (bus_a.cen !== 1'b1) $display("FAIL abort_cen: got %b expected 1", bus_a.cen); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_cen_div();
        do_reset();
        for (int j = 0; j < 4; j++) begin
            logic exp_c;
            exp_c = (j % 2 == 0);
            n_chk++; if (bus_b.cen !== exp_c) $display("FAIL cen_div[%0d]: got %b expected %b", j, bus_b.cen, exp_c); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_wait();
        logic [15:0] d0;
        int          n;
        do_reset();
        n = 0;
        while (bus_b.rdy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_chk++; if (bus_b.rdy !== 1'b1) $display("FAIL wait_initial_rdy: got %b expected 1", bus_b.rdy); else n_pass++;
        d0 = 16'($urandom);
        bus_b.addr = {12'h000, 11'($urandom_range(1, 1000)), 1'b0};
        bus_b.dout = d0; bus_b.we = 2'b11;
        // ready stays low for exactly WAIT cycles counted from the change
        for (int j = 0; j <= WAIT_B; j++) begin
            logic exp_r;
            if (j == 0) #1;
            else        @(negedge clk);
            exp_r = (j >= WAIT_B);
            n_chk++; if (bus_b.rdy !== exp_r) $display("FAIL wait_rdy[%0d]: got %b expected %b", j, bus_b.rdy, exp_r); else n_pass++;
        end
        repeat (2) @(negedge clk);
        bus_b.we = 2'b00;
        #1;
        n_chk++; if (bus_b.din !== d0) $display("FAIL wait_write: got %h expected %h", bus_b.din, d0); else n_pass++;
        repeat (WAIT_B + 1) @(negedge clk);
        bus_b.dout = ~d0; bus_b.we = 2'b11;
        repeat (WAIT_B) @(negedge clk);
        bus_b.we = 2'b00;
        #1;
        n_chk++; if (bus_b.din !== d0) $display("FAIL wait_blocked_write: got %h expected %h", bus_b.din, d0); else n_pass++;
    endtask

    task automatic test_timeout();
        int c;
        int i;
        do_reset();
        for (int k = 0; k < DMP_B; k++) rf_b[k] = 8'($urandom);
        c = 0;
        while (st_b == ST_RUN && c < TMO_B + 10) begin
            @(negedge clk);
            c++;
        end
        n_chk++; if (c !== TMO_B) $display("FAIL tmo_cycle: got %0d expected %0d", c, TMO_B); else n_pass++;
        n_chk++; if (st_b !== ST_DUMP) $display("FAIL tmo_st: got %0d expected 1", st_b); else n_pass++;
        n_chk++; if (tmo_b !== 1'b1) $display("FAIL tmo_flag: got %b expected 1", tmo_b); else n_pass++;
        n_chk++; if (bus_b.cen !== 1'b0) $display("FAIL tmo_cen: got %b expected 0", bus_b.cen); else n_pass++;
        i = 0;
        while (st_b == ST_DUMP && i <= DMP_B + 4) begin
            dmp_din_b = (i > 0 && i <= DMP_B) ? rf_b[i-1] : 8'($urandom);
            @(negedge clk);
            i++;
        end
        n_chk++; if (st_b !== ST_DONE) $display("FAIL tmo_done: got %0d expected 2", st_b); else n_pass++;
        for (int a = 0; a < DMP_B + 2; a++) begin
            logic [7:0] exp_q;
            exp_q   = (a < DMP_B) ? rf_b[a] : 8'h00;
            buf_a_b = 8'(a);
            #1;
            n_chk++; if (buf_q_b !== exp_q) $display("FAIL buf_b[%0d]: got %h expected %h", a, buf_q_b, exp_q); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_stop();
        test_reset_in_dump();
        test_cen_div();
        test_wait();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
